// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
// Contents:
//   csa_state_t  - controller states; the split-resolve encodings always exist
//   acc_width()  - accumulator/result width for a given operand width and beat limit
//   beat_width() - width of the beat counter (must be able to hold MAX_BEATS)
package csa_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACCUM      = 3'd1,
    RESOLVE    = 3'd2,
    DONE       = 3'd3,
    RESOLVE_LO = 3'd4,
    RESOLVE_HI = 3'd5
  } csa_state_t;

  // One guard bit on top of the log2 growth keeps forced-length sums exact.
  function automatic int unsigned acc_width(input int unsigned width,
                                            input int unsigned max_beats);
    return width + $clog2(max_beats) + 1;
  endfunction

  function automatic int unsigned beat_width(input int unsigned max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/compress42_row.sv
// One row of 4:2 compressors reducing four ACC_WIDTH-bit rows to sum + carry.
// Ports:
//   in0..in3 - rows to reduce (all weight-aligned)
//   sum      - per-column sum bits, weight 2^i
//   carry    - carry out of column i (weight 2^(i+1)) for columns 0..ACC_WIDTH-2;
//              the top column's carry and its chain Cout fall off the result width
// Purely combinational; the inter-column Cout->Cin chain lives inside.
module compress42_row #(
  parameter int unsigned ACC_WIDTH = 21
) (
  input  logic [ACC_WIDTH-1:0] in0,
  input  logic [ACC_WIDTH-1:0] in1,
  input  logic [ACC_WIDTH-1:0] in2,
  input  logic [ACC_WIDTH-1:0] in3,
  output logic [ACC_WIDTH-1:0] sum,
  output logic [ACC_WIDTH-2:0] carry
);

  // cin_col[i] is the chain carry entering column i; column 0 has none.
  logic [ACC_WIDTH-1:0] cin_col;

  assign cin_col[0] = 1'b0;

  for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_col
    logic s1;

    // First full adder over in0..in2, second over s1, in3 and the chain carry.
    assign s1     = in0[i] ^ in1[i] ^ in2[i];
    assign sum[i] = s1 ^ in3[i] ^ cin_col[i];

    if (i < ACC_WIDTH - 1) begin : g_carry
      assign cin_col[i+1] = (in0[i] & in1[i]) | (in0[i] & in2[i]) | (in1[i] & in2[i]);
      assign carry[i]     = (s1 & in3[i]) | (s1 & cin_col[i]) | (in3[i] & cin_col[i]);
    end
  end

endmodule

// File: rtl/carry_save_accumulator.sv
// Sequential multi-operand adder: folds a stream of operand pairs into a
// carry-save accumulator through a single reused 4:2 compressor row, then
// resolves it with a carry-propagate add and presents the sum.
// Ports:
//   clk, reset_n         - clock, synchronous active-low reset
//   in_valid/in_ready    - operand pair handshake; in_a, in_b operands, in_last ends txn
//   out_valid/out_ready  - result handshake; out_sum (mod 2^ACC_WIDTH), out_beats
//   busy                 - controller not idle
// Build option: define CSA_CPA_PIPE_EN to split the final add over two cycles
// (low half, then high half plus registered carry); results are identical.
module carry_save_accumulator
  import csa_pkg::*;
#(
  parameter  int unsigned WIDTH      = 16,
  parameter  int unsigned MAX_BEATS  = 16,
  localparam int unsigned ACC_WIDTH  = acc_width(WIDTH, MAX_BEATS),
  localparam int unsigned BEAT_WIDTH = beat_width(MAX_BEATS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [BEAT_WIDTH-1:0] out_beats,
  output logic                  busy
);

`ifdef CSA_CPA_PIPE_EN
  localparam csa_state_t RES_FIRST = RESOLVE_LO;
`else
  localparam csa_state_t RES_FIRST = RESOLVE;
`endif

  csa_state_t state, next_state;

  logic [ACC_WIDTH-1:0]  acc_sum;
  logic [ACC_WIDTH-2:0]  acc_carry;   // top carry bit would be shifted out, so never stored
  logic [ACC_WIDTH-1:0]  carry_sh;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic [BEAT_WIDTH-1:0] beat_next;
  logic [ACC_WIDTH-1:0]  op_sum;
  logic [ACC_WIDTH-1:0]  op_carry;
  logic [ACC_WIDTH-1:0]  row_sum;
  logic [ACC_WIDTH-2:0]  row_carry;
  logic                  can_accept;
  logic                  accept;
  logic                  terminate;

  assign carry_sh = {acc_carry, 1'b0};

  // Next-state and beat bookkeeping.
  always_comb begin
    next_state = state;
    can_accept = (state == IDLE) || (state == ACCUM);
    accept     = in_valid && can_accept;
    beat_next  = (state == IDLE) ? BEAT_WIDTH'(1) : beat_cnt + BEAT_WIDTH'(1);
    terminate  = in_last || (beat_next == BEAT_WIDTH'(MAX_BEATS));
    // First beat of a transaction sees zero state, which clears the accumulator.
    op_sum     = (state == IDLE) ? '0 : acc_sum;
    op_carry   = (state == IDLE) ? '0 : carry_sh;

    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          next_state = terminate ? RES_FIRST : ACCUM;
        end
      end
      RESOLVE:    next_state = DONE;
      RESOLVE_LO: next_state = RESOLVE_HI;
      RESOLVE_HI: next_state = DONE;
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default:    next_state = IDLE;
    endcase
  end

  compress42_row #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_row (
    .in0   (ACC_WIDTH'(in_a)),
    .in1   (ACC_WIDTH'(in_b)),
    .in2   (op_sum),
    .in3   (op_carry),
    .sum   (row_sum),
    .carry (row_carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

`ifdef CSA_CPA_PIPE_EN
  localparam int unsigned LO_W  = ACC_WIDTH / 2;
  localparam int unsigned LO_W1 = LO_W + 1;
  localparam int unsigned HI_W  = ACC_WIDTH - LO_W;

  logic [LO_W-1:0] res_lo;
  logic            cpa_carry;
  logic [LO_W:0]   lo_add;
  logic [HI_W-1:0] hi_add;

  assign lo_add = LO_W1'(acc_sum[LO_W-1:0]) + LO_W1'(carry_sh[LO_W-1:0]);
  assign hi_add = acc_sum[ACC_WIDTH-1:LO_W] + carry_sh[ACC_WIDTH-1:LO_W] + HI_W'(cpa_carry);
`endif

  // Registered outputs and datapath; status flags track the upcoming state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      acc_sum   <= '0;
      acc_carry <= '0;
      beat_cnt  <= '0;
      out_sum   <= '0;
      out_beats <= '0;
`ifdef CSA_CPA_PIPE_EN
      res_lo    <= '0;
      cpa_carry <= 1'b0;
`endif
    end else begin
      in_ready  <= (next_state == IDLE) || (next_state == ACCUM);
      busy      <= next_state != IDLE;
      out_valid <= next_state == DONE;

      if (accept) begin
        acc_sum   <= row_sum;
        acc_carry <= row_carry;
        beat_cnt  <= beat_next;
      end

      case (state)
`ifdef CSA_CPA_PIPE_EN
        RESOLVE_LO: begin
          res_lo    <= lo_add[LO_W-1:0];
          cpa_carry <= lo_add[LO_W];
        end
        RESOLVE_HI: begin
          out_sum   <= {hi_add, res_lo};
          out_beats <= beat_cnt;
        end
`else
        RESOLVE: begin
          out_sum   <= acc_sum + carry_sh;
          out_beats <= beat_cnt;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_save_accumulator.sv
// Self-checking bench for carry_save_accumulator (WIDTH=8, MAX_BEATS=4).
// Transactions come from a table; results are checked through a scoreboard
// queue plus per-cycle handshake/latency checks around each transaction.
module tb_carry_save_accumulator;

`ifdef CSA_CPA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_sum;
  logic [2:0]  out_beats;
  logic        busy;

  carry_save_accumulator #(
    .WIDTH     (8),
    .MAX_BEATS (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_beats (out_beats),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    int         gap;
    int         hold;
    bit         use_last;
    logic [7:0] a [4];
    logic [7:0] b [4];
    logic [10:0] exp_sum;
    logic [2:0]  exp_beats;
  } vec_t;

  typedef struct packed {
    logic [10:0] sum;
    logic [2:0]  beats;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat i of a transaction takes byte i (LSB first) of a_pk/b_pk.
  function automatic vec_t mk(input int n, input int gap, input int hold, input bit use_last,
                              input logic [31:0] a_pk, input logic [31:0] b_pk,
                              input logic [10:0] s, input logic [2:0] bt);
    vec_t v;
    v.n = n; v.gap = gap; v.hold = hold; v.use_last = use_last;
    for (int i = 0; i < 4; i++) begin
      v.a[i] = a_pk[8*i +: 8];
      v.b[i] = b_pk[8*i +: 8];
    end
    v.exp_sum = s; v.exp_beats = bt;
    return v;
  endfunction

  // Scoreboard: a result is consumed at the edge following out_valid && out_ready.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got sum %0h beats %0d with no result expected", out_sum, out_beats);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_sum", 32'(out_sum), 32'(e.sum));
        chk("sb_beats", 32'(out_beats), 32'(e.beats));
      end
    end
  end

  task automatic run_txn(input vec_t v);
    logic [10:0] part;
    logic [10:0] acc_view;
    int t;
    part = '0;
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_a     = v.a[i];
      in_b     = v.b[i];
      in_last  = v.use_last && (i == v.n - 1);
      if (i == v.n - 1) exp_q.push_back('{sum: v.exp_sum, beats: v.exp_beats});
      t = 0;
      while (!in_ready && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      chk("in_ready_at_beat", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      part     = part + 11'(v.a[i]) + 11'(v.b[i]);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i < v.n - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          @(posedge clk); #1;
          acc_view = dut.acc_sum + {dut.acc_carry, 1'b0};
          chk("gap_acc", 32'(acc_view), 32'(part));
          chk("gap_in_ready", 32'(in_ready), 32'd1);
          chk("gap_out_valid", 32'(out_valid), 32'd0);
        end
      end
    end
    // Terminating beat just accepted.
    chk("resolve_in_ready", 32'(in_ready), 32'd0);
    chk("resolve_busy", 32'(busy), 32'd1);
    chk("resolve_out_valid", 32'(out_valid), 32'd0);
    repeat (LAT) begin
      @(posedge clk); #1;
    end
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_sum", 32'(out_sum), 32'(v.exp_sum));
      chk("hold_out_beats", 32'(out_beats), 32'(v.exp_beats));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_sum_kept", 32'(out_sum), 32'(v.exp_sum));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  vec_t vecs [7];

  initial begin
    vecs[0] = mk(1, 0, 5, 1'b1, 32'h000000FF, 32'h00000001, 11'h100, 3'd1);
    vecs[1] = mk(3, 0, 0, 1'b1, 32'h00321E0A, 32'h003C2814, 11'd210, 3'd3);
    vecs[2] = mk(4, 0, 2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 11'h7F8, 3'd4);
    vecs[3] = mk(2, 0, 0, 1'b1, 32'h0000FF80, 32'h00000080, 11'h1FF, 3'd2);
    vecs[4] = mk(2, 3, 0, 1'b1, 32'h00000107, 32'h00000109, 11'd18, 3'd2);
    vecs[5] = mk(4, 1, 1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 11'h7F8, 3'd4);
    vecs[6] = mk(2, 0, 0, 1'b1, 32'h00000000, 32'h00000000, 11'd0, 3'd2);

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < 7; k++) begin
      run_txn(vecs[k]);
    end

    // Abort a transaction after two accepted beats.
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd4; in_last = 1'b0;
    @(posedge clk); #1;
    in_a = 8'd5; in_b = 8'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_out_beats", 32'(out_beats), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    run_txn(mk(1, 0, 0, 1'b1, 32'h00000005, 32'h00000006, 11'd11, 3'd1));

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
